icache: RTL and testbench

Direct-mapped, single-word-block instruction cache between the pipelined datapath's fetch stage and the memory controller. It serves fetch requests from its frames in the same cycle on a hit. On a miss it runs a blocking fill from memory and then reports a hit once the frame is valid. It also keeps hit and miss event counters for performance analysis.

---
 rtl/cpu_types_pkg.sv | 31 +++
 rtl/icache_array.sv | 47 ++++
 rtl/icache.sv | 102 ++++++++++
 tb/tb_icache.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the instruction cache: word type, address view,
// frame layout and controller states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int DEF_FRAMES = 16;
  localparam int DEF_IDX_W  = $clog2(DEF_FRAMES);
  localparam int DEF_TAG_W  = 30 - DEF_IDX_W;

  // Widest tag any legal FRAMES (>= 2) can produce; narrower tags are zero-extended.
  localparam int TAG_MAX_W  = 29;

  typedef struct packed {
    logic [DEF_TAG_W-1:0] tag;
    logic [DEF_IDX_W-1:0] idx;
    logic [1:0]           bytoff;
  } icachef_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    word_t                data;
  } icache_frame_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache_array.sv
// Direct-mapped frame storage: combinational read port, one write port,
// and a single-cycle clear of every valid bit.
module icache_array
  import cpu_types_pkg::*;
#(
  parameter int FRAMES = 16,
  parameter int IDX_W  = $clog2(FRAMES)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [IDX_W-1:0] rd_idx,
  output icache_frame_t    rd_frame,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  icache_frame_t    wr_frame,
  input  logic             clear
);

  logic [FRAMES-1:0]    valid;
  logic [TAG_MAX_W-1:0] tags [FRAMES];
  word_t                data [FRAMES];

  // Clear wins over a write so a flush can never leave a stale frame valid.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid <= '0;
    end else if (clear) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= wr_frame.valid;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      tags[wr_idx] <= wr_frame.tag;
      data[wr_idx] <= wr_frame.data;
    end
  end

  always_comb begin
    rd_frame.valid = valid[rd_idx];
    rd_frame.tag   = tags[rd_idx];
    rd_frame.data  = data[rd_idx];
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: same-cycle hits, blocking single-word
// fill on a miss, flush-all, and hit/miss event counters.
module icache
  import cpu_types_pkg::*;
#(
  parameter int FRAMES = 16,
  parameter int IDX_W  = $clog2(FRAMES)
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  imemREN,
  input  word_t imemaddr,
  output logic  ihit,
  output word_t imemload,
  input  logic  iwait,
  input  word_t iload,
  output logic  iREN,
  output word_t iaddr,
  input  logic  flush,
  output word_t hit_count,
  output word_t miss_count
);

  icache_state_t state, next_state;
  word_t         miss_addr;
  logic          discard;
  icache_frame_t rd_frame, wr_frame;
  logic          wr_en;
  logic          lookup_hit, miss, fill_done;
  logic [TAG_MAX_W-1:0] req_tag, fill_tag;

  assign req_tag  = TAG_MAX_W'(imemaddr >> (IDX_W + 2));
  assign fill_tag = TAG_MAX_W'(miss_addr >> (IDX_W + 2));

  assign lookup_hit = (state == IDLE) && imemREN && !flush &&
                      rd_frame.valid && (rd_frame.tag == req_tag);
  assign miss       = (state == IDLE) && imemREN && !lookup_hit;
  assign fill_done  = (state == FILL) && !iwait;

  // A flush seen in this FILL, now or earlier, suppresses the frame write.
  assign wr_en          = fill_done && !discard && !flush;
  assign wr_frame.valid = 1'b1;
  assign wr_frame.tag   = fill_tag;
  assign wr_frame.data  = iload;

  icache_array #(.FRAMES(FRAMES), .IDX_W(IDX_W)) u_array (
    .CLK      (CLK),
    .RST      (RST),
    .rd_idx   (imemaddr[IDX_W+1:2]),
    .rd_frame (rd_frame),
    .wr_en    (wr_en),
    .wr_idx   (miss_addr[IDX_W+1:2]),
    .wr_frame (wr_frame),
    .clear    (flush)
  );

  always_comb begin
    next_state = state;
    ihit       = 1'b0;
    imemload   = '0;
    iREN       = 1'b0;
    iaddr      = '0;
    case (state)
      IDLE: begin
        if (lookup_hit) begin
          ihit     = 1'b1;
          imemload = rd_frame.data;
        end else if (imemREN) begin
          next_state = FILL;
        end
      end
      FILL: begin
        iREN  = 1'b1;
        iaddr = miss_addr;
        if (!iwait) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      miss_addr  <= '0;
      discard    <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state <= next_state;
      if (miss) begin
        miss_addr  <= {imemaddr[31:2], 2'b00};
        miss_count <= miss_count + 32'd1;
      end
      if (ihit) hit_count <= hit_count + 32'd1;
      if (fill_done)
        discard <= 1'b0;
      else if ((state == FILL) && flush)
        discard <= 1'b1;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed, self-checking bench for icache with FRAMES=16.
module tb_icache;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iwait;
  logic [31:0] iload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        flush;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int nChecks = 0;
  int nFails  = 0;
  int expHits = 0;
  int expMiss = 0;

  icache #(.FRAMES(16)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .ihit       (ihit),
    .imemload   (imemload),
    .iwait      (iwait),
    .iload      (iload),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .flush      (flush),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ren, input logic [31:0] addr,
                               input logic wt, input logic [31:0] ld, input logic fl);
    imemREN  = ren;
    imemaddr = addr;
    iwait    = wt;
    iload    = ld;
    flush    = fl;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Full miss: lookup misses in IDLE, nWait busy cycles, one completing cycle.
  task automatic fillMiss(input logic [31:0] addr, input logic [31:0] data, input int nWait);
    applyStimulus(1'b1, addr, 1'b1, 32'h0, 1'b0);
    settle();
    checkOutput("miss_ihit", {31'b0, ihit}, 32'd0);
    checkOutput("miss_iREN_idle", {31'b0, iREN}, 32'd0);
    tick();
    expMiss++;
    for (int i = 0; i < nWait; i++) begin
      checkOutput("fill_iREN", {31'b0, iREN}, 32'd1);
      checkOutput("fill_iaddr", iaddr, addr);
      tick();
    end
    applyStimulus(1'b1, addr, 1'b0, data, 1'b0);
    settle();
    checkOutput("fill_last_iaddr", iaddr, addr);
    checkOutput("fill_ihit", {31'b0, ihit}, 32'd0);
    tick();
    checkOutput("after_fill_ihit", {31'b0, ihit}, 32'd1);
    checkOutput("after_fill_data", imemload, data);
    checkOutput("after_fill_iREN", {31'b0, iREN}, 32'd0);
  endtask

  task automatic goIdle();
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
    settle();
    tick();
  endtask

  initial begin
    RST = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
    #12;
    checkOutput("rst_ihit", {31'b0, ihit}, 32'd0);
    checkOutput("rst_iREN", {31'b0, iREN}, 32'd0);
    checkOutput("rst_iaddr", iaddr, 32'd0);
    checkOutput("rst_imemload", imemload, 32'd0);
    checkOutput("rst_hit_count", hit_count, 32'd0);
    checkOutput("rst_miss_count", miss_count, 32'd0);
    RST = 1'b0;
    tick();

    // Cold miss with three busy cycles
    fillMiss(32'h0000_0040, 32'h8C22_0004, 3);
    checkOutput("t1_miss_count", miss_count, 32'd1);
    checkOutput("t1_hit_count", hit_count, 32'd0);
    applyStimulus(1'b0, 32'h0000_0040, 1'b1, 32'h0, 1'b0);
    settle();
    checkOutput("idle_noreq_ihit", {31'b0, ihit}, 32'd0);
    checkOutput("idle_noreq_load", imemload, 32'd0);
    tick();
    checkOutput("idle_noreq_hits", hit_count, 32'd0);

    // Conflict misses on index 0
    fillMiss(32'h0000_0440, 32'h1111_1111, 1);
    goIdle();
    fillMiss(32'h0000_0040, 32'h2222_2222, 0);
    checkOutput("t2_miss_count", miss_count, 32'd3);
    goIdle();

    // Back-to-back hits alternating two frames
    fillMiss(32'h0000_0000, 32'hA000_0000, 0);
    fillMiss(32'h0000_0004, 32'hA000_0004, 2);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, (i % 2 == 0) ? 32'h0 : 32'h4, 1'b1, 32'h0, 1'b0);
      settle();
      checkOutput("b2b_ihit", {31'b0, ihit}, 32'd1);
      checkOutput("b2b_iREN", {31'b0, iREN}, 32'd0);
      checkOutput("b2b_data", imemload, (i % 2 == 0) ? 32'hA000_0000 : 32'hA000_0004);
      tick();
      expHits++;
    end
    goIdle();
    checkOutput("b2b_hit_count", hit_count, 32'(expHits));
    checkOutput("b2b_miss_count", miss_count, 32'd5);

    // Flush during FILL discards the completing fill
    applyStimulus(1'b1, 32'h0000_0008, 1'b1, 32'h0, 1'b0);
    settle();
    tick();
    expMiss++;
    applyStimulus(1'b1, 32'h0000_0008, 1'b1, 32'h0, 1'b1);
    settle();
    tick();
    applyStimulus(1'b1, 32'h0000_0008, 1'b0, 32'hDEAD_0008, 1'b0);
    settle();
    checkOutput("flush_fill_iREN", {31'b0, iREN}, 32'd1);
    tick();
    checkOutput("flush_relookup_ihit", {31'b0, ihit}, 32'd0);
    applyStimulus(1'b1, 32'h0000_0000, 1'b1, 32'h0, 1'b0);
    settle();
    checkOutput("flush_old_ihit", {31'b0, ihit}, 32'd0);
    goIdle();
    checkOutput("flush_miss_count", miss_count, 32'(expMiss));
    fillMiss(32'h0000_0008, 32'h0000_0808, 0);
    goIdle();

    // Address change during FILL is ignored
    applyStimulus(1'b1, 32'h0000_0010, 1'b1, 32'h0, 1'b0);
    settle();
    tick();
    expMiss++;
    applyStimulus(1'b1, 32'h0000_0020, 1'b1, 32'h0, 1'b0);
    settle();
    checkOutput("addrchg_iaddr1", iaddr, 32'h0000_0010);
    tick();
    checkOutput("addrchg_iaddr2", iaddr, 32'h0000_0010);
    applyStimulus(1'b1, 32'h0000_0020, 1'b0, 32'h0000_1010, 1'b0);
    settle();
    checkOutput("addrchg_iaddr3", iaddr, 32'h0000_0010);
    tick();
    checkOutput("addrchg_0x20_ihit", {31'b0, ihit}, 32'd0);
    applyStimulus(1'b1, 32'h0000_0010, 1'b1, 32'h0, 1'b0);
    settle();
    checkOutput("addrchg_0x10_ihit", {31'b0, ihit}, 32'd1);
    checkOutput("addrchg_0x10_data", imemload, 32'h0000_1010);
    goIdle();
    checkOutput("addrchg_miss_count", miss_count, 32'(expMiss));

    // Reset in the middle of a FILL
    applyStimulus(1'b1, 32'h0000_0080, 1'b1, 32'h0, 1'b0);
    settle();
    tick();
    checkOutput("rstfill_iREN_before", {31'b0, iREN}, 32'd1);
    RST = 1'b1;
    settle();
    checkOutput("rstfill_iREN", {31'b0, iREN}, 32'd0);
    checkOutput("rstfill_iaddr", iaddr, 32'd0);
    checkOutput("rstfill_hits", hit_count, 32'd0);
    checkOutput("rstfill_misses", miss_count, 32'd0);
    tick();
    RST = 1'b0;
    applyStimulus(1'b1, 32'h0000_0000, 1'b1, 32'h0, 1'b0);
    settle();
    checkOutput("post_rst_0x0", {31'b0, ihit}, 32'd0);
    applyStimulus(1'b1, 32'h0000_0004, 1'b1, 32'h0, 1'b0);
    settle();
    checkOutput("post_rst_0x4", {31'b0, ihit}, 32'd0);
    applyStimulus(1'b1, 32'h0000_0010, 1'b1, 32'h0, 1'b0);
    settle();
    checkOutput("post_rst_0x10", {31'b0, ihit}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
